// File: rtl/fp_sum_arbiter.sv
// Two-requester round-robin front end for a shared pipelined FP adder.
// Caps in-flight ops per requester and routes tagged results back to their owners.
package fp_sum_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;
endpackage

module fp_sum_arbiter
  import fp_sum_pkg::*;
#(
  parameter int LAT     = 4,
  parameter int MAX_OUT = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req0_vld_i,
  input  float_point_num req0_a_i,
  input  float_point_num req0_b_i,
  output logic           req0_rdy_o,
  input  logic           req1_vld_i,
  input  float_point_num req1_a_i,
  input  float_point_num req1_b_i,
  output logic           req1_rdy_o,
  output float_point_num add_a_o,
  output float_point_num add_b_o,
  output logic           add_vld_o,
  input  float_point_num add_answer_i,
  input  logic [1:0]     add_status_i,
  output logic           res_vld_o,
  output logic           res_id_o,
  output float_point_num res_answer_o,
  output logic [1:0]     res_status_o,
  output logic           busy_o
);

  localparam int            CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [CW-1:0]  cnt0, cnt1;
  logic           ptr;
  logic [LAT-1:0] tag_vld;
  logic [LAT-1:0] tag_id;
  logic           elig0, elig1;
  logic           grant0, grant1;
  logic           ret0, ret1;

  // Reset gates eligibility so nothing is offered while rst_i is high.
  assign elig0 = req0_vld_i && !rst_i && (cnt0 < MAX_CNT);
  assign elig1 = req1_vld_i && !rst_i && (cnt1 < MAX_CNT);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = ~ptr;
      grant1 = ptr;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_rdy_o = grant0;
  assign req1_rdy_o = grant1;
  assign add_vld_o  = grant0 | grant1;

  always_comb begin
    add_a_o = '0;
    add_b_o = '0;
    if (grant0) begin
      add_a_o = req0_a_i;
      add_b_o = req0_b_i;
    end else if (grant1) begin
      add_a_o = req1_a_i;
      add_b_o = req1_b_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

  // Tag pipeline mirrors the adder latency; it never stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= add_vld_o;
      tag_id[0]  <= grant1;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign res_vld_o    = tag_vld[LAT-1];
  assign res_id_o     = tag_id[LAT-1];
  assign res_answer_o = res_vld_o ? add_answer_i : '0;
  assign res_status_o = res_vld_o ? add_status_i : 2'b00;
  assign busy_o       = |tag_vld;

  assign ret0 = res_vld_o & ~res_id_o;
  assign ret1 = res_vld_o &  res_id_o;

  // Simultaneous issue and retire leave the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      case ({grant0, ret0})
        2'b10:   cnt0 <= cnt0 + CW'(1);
        2'b01:   cnt0 <= cnt0 - CW'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({grant1, ret1})
        2'b10:   cnt1 <= cnt1 + CW'(1);
        2'b01:   cnt1 <= cnt1 - CW'(1);
        default: cnt1 <= cnt1;
      endcase
    end
  end

endmodule

// File: doc/fp_sum_arbiter.md
FP_SUM_ARBITER -- requirements
Module: fp_sum_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning the adder's issue-to-answer latency in clk_i cycles (LAT >= 1).
REQ-002 SHALL have parameter MAX_OUT, default 3, meaning the per-requester limit on in-flight operations (1..7).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports req0_vld_i/req1_vld_i, input, 1 bit each: the requester presents an operand pair.
REQ-006 SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i, input, float_point_num (32 bits: sign, exp[7:0], mant[22:0]): operands.
REQ-007 SHALL have ports req0_rdy_o/req1_rdy_o, output, 1 bit each: the request is accepted this cycle.
REQ-008 SHALL have ports add_a_o/add_b_o, output, float_point_num, and add_vld_o, output, 1 bit: issue port to the shared pipelined FP adder.
REQ-009 SHALL have ports add_answer_i, input, float_point_num, and add_status_i, input, 2 bits: adder result and number status, both aligned LAT cycles after issue.
REQ-010 SHALL have ports res_vld_o, output, 1 bit; res_id_o, output, 1 bit; res_answer_o, output, float_point_num; res_status_o, output, 2 bits: the returned result and its owning requester.
REQ-011 SHALL have port busy_o, output, 1 bit: at least one operation is in flight.

Function
REQ-012 Requester n SHALL be eligible when reqn_vld_i=1 and outstanding count cnt_n < MAX_OUT.
REQ-013 Grant SHALL be combinational: one eligible requester -> grant it; both eligible -> grant the one selected by round-robin pointer ptr; none -> no grant.
REQ-014 reqn_rdy_o SHALL equal grant_n; a transfer occurs when reqn_vld_i and reqn_rdy_o are both 1; at most one grant per cycle.
REQ-015 After a grant to requester n, ptr SHALL become 1-n; with no grant ptr SHALL hold.
REQ-016 add_vld_o SHALL equal grant0|grant1; add_a_o/add_b_o SHALL carry the granted requester's operands, and SHALL be all-zero when there is no grant.
REQ-017 A tag pipeline of LAT stages (valid bit + id bit) SHALL shift every cycle with no stall; stage 0 loads {add_vld_o, granted id}.
REQ-018 res_vld_o/res_id_o SHALL be the last tag stage; res_answer_o/res_status_o SHALL pass add_answer_i/add_status_i through when res_vld_o=1, and SHALL be zero otherwise.
REQ-019 Results SHALL return in issue order; a request issued at cycle t SHALL appear at cycle t+LAT with a single-cycle res_vld_o pulse; there is no result back-pressure.
REQ-020 cnt_n SHALL be ceil(log2(MAX_OUT+1)) bits wide and SHALL increment on grant_n and decrement when res_vld_o=1 with res_id_o=n; when both occur in the same cycle it SHALL hold.
REQ-021 When cnt_n = MAX_OUT, reqn_rdy_o SHALL be 0 and the other requester SHALL get every slot it requests.
REQ-022 In the same cycle a retirement frees a slot, the blocked requester SHALL NOT become eligible; it becomes eligible the following cycle (cnt is registered).
REQ-023 busy_o SHALL be the OR of all tag valid bits.
REQ-024 Back-to-back issue SHALL sustain one operation per cycle when the two requesters alternate within their limits.

Reset
REQ-025 While rst_i=1, asynchronously: tags cleared, cnt0=cnt1=0, ptr=0; req*_rdy_o, add_vld_o, res_vld_o, busy_o SHALL be 0; add_*_o and res_* data SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight tags, so no res_vld_o follows for pre-reset issues; adder results arriving later SHALL be ignored.
REQ-027 The first cycle after reset release SHALL accept requests, with requester 0 winning a tie.

Verification
REQ-028 Single request: req0 issues a=1.0 (0x3F800000), b=2.0 (0x40000000) at cycle t -> add_vld_o=1 at t; res_vld_o=1, res_id_o=0, res_answer_o=0x40400000 at t+4.
REQ-029 Contention: both vld held for 4 cycles after reset -> grants 0,1,0,1; results return with res_id_o 0,1,0,1 at LAT spacing of one cycle.
REQ-030 Limit: only req0 valid continuously, MAX_OUT=3 -> grants at cycles 0,1,2; rdy0=0 at cycles 3..4; next grant at cycle 5, the cycle after the first retirement.
REQ-031 Simultaneous issue+retire: cnt0=2, grant0 in the same cycle a result with id 0 returns -> cnt0 stays 2 and busy_o stays 1.
REQ-032 Reset mid-flight: issue 3 ops, assert rst_i for 1 cycle before any return -> no res_vld_o afterward; busy_o=0; cnt0=cnt1=0.
